// File: rtl/tt_edge_capture_pkg.sv
// Shared types and constants for the edge-capture tile.
package tt_edge_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned BUSY_BIT = 0;
  localparam int unsigned DONE_BIT = 1;
  localparam int unsigned OVF_BIT  = 2;

  localparam logic [7:0] UIO_OE_MASK = 8'h07;

  function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// Two-flop synchronizer followed by a rising-edge register; one-cycle pulse per rise.
module edge_sync_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge_pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/tt_um_edge_capture.sv
// Gated rising-edge counter: counts sig_in edges over a programmable window and
// latches the total for byte-wise readout.
module tt_um_edge_capture
  import tt_edge_capture_pkg::*;
#(
  parameter int unsigned GATE_UNIT = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned GW = $clog2(32 * GATE_UNIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_edge_pulse;
  logic             w_start_edge;
  logic             w_at_max;
  logic [CNT_W-1:0] w_cnt_next;
  logic [GW-1:0]    w_gate_load;
  logic [7:0]       w_uio_out;
  logic             w_unused;

  state_e           r_state;
  logic             r_start_q;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [GW-1:0]    r_gate;
  logic [15:0]      r_result;

  edge_sync_detect u_sig_sync (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sig        (ui_in[0]),
    .o_edge_pulse (w_edge_pulse)
  );

  assign w_start_edge = ui_in[1] & ~r_start_q;
  assign w_at_max     = (r_edge_cnt == CNT_MAX);
  assign w_cnt_next   = (w_edge_pulse && !w_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_gate_load  = GW'((32'(ui_in[7:3]) + 32'd1) * GATE_UNIT - 32'd1);

  // Resets high so a start held through reset release does not arm a window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b1;
    end else begin
      r_start_q <= ui_in[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_edge_cnt <= '0;
      r_gate     <= '0;
      r_result   <= '0;
    end else if (ena) begin
      case (r_state)
        IDLE: begin
          if (w_start_edge) r_state <= ARM;
        end
        ARM: begin
          r_edge_cnt <= '0;
          r_gate     <= w_gate_load;
          r_busy     <= 1'b1;
          r_done     <= 1'b0;
          r_ovf      <= 1'b0;
          r_state    <= COUNT;
        end
        COUNT: begin
          r_edge_cnt <= w_cnt_next;
          if (w_edge_pulse && w_at_max) r_ovf <= 1'b1;
          // Final cycle of the window still contributes its edge.
          if (r_gate == '0) begin
            r_result <= 16'(w_cnt_next);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_gate <= r_gate - GW'(1);
          end
        end
        DONE: begin
          if (w_start_edge) r_state <= ARM;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_uio_out           = '0;
    w_uio_out[BUSY_BIT] = r_busy;
    w_uio_out[DONE_BIT] = r_done;
    w_uio_out[OVF_BIT]  = r_ovf;
  end

  assign uo_out   = sel_byte(r_result, ui_in[2]);
  assign uio_out  = w_uio_out;
  assign uio_oe   = UIO_OE_MASK;
  assign w_unused = ^uio_in;

endmodule

// File: tb/tb_tt_um_edge_capture.sv
// Directed bench for tt_um_edge_capture: default instance plus a CNT_W=4 instance
// sharing the same stimulus.
module tb_tt_um_edge_capture;
  import tt_edge_capture_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;
  wire  [7:0] uo_out4;
  wire  [7:0] uio_out4;
  wire  [7:0] uio_oe4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned busy_total = 0;
  int unsigned busy_snap;

  tt_um_edge_capture u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  tt_um_edge_capture #(
    .GATE_UNIT (16),
    .CNT_W     (4)
  ) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out4),
    .uio_in  (uio_in),
    .uio_out (uio_out4),
    .uio_oe  (uio_oe4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (uio_out[BUSY_BIT] === 1'b1) busy_total++;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge after the one where start rose.
  task automatic start_window();
    busy_snap = busy_total;
    ui_in[1] = 1'b1;
    tick(1);
    ui_in[1] = 1'b0;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      ui_in[0] = 1'b1;
      tick(2);
      ui_in[0] = 1'b0;
      tick(2);
    end
  endtask

  task automatic wait_done(input int max_cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      if (uio_out[DONE_BIT] === 1'b1) seen = 1'b1;
      else tick(1);
    end
    check_eq(tag, 16'(seen), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h02;  // start held high through reset

    // Reset and idle
    tick(3);
    check_eq("rst_uo_out", 16'(uo_out), 16'h00);
    check_eq("rst_uio_out", 16'(uio_out), 16'h00);
    check_eq("rst_uio_oe", 16'(uio_oe), 16'h07);
    check_eq("rst_uio_out4", 16'(uio_out4), 16'h00);
    rst_n = 1'b1;
    busy_snap = busy_total;
    tick(10);
    check_eq("idle_no_arm_busy", 16'(busy_total - busy_snap), 16'd0);
    check_eq("idle_uio_out", 16'(uio_out), 16'h00);
    check_eq("idle_uio_oe4", 16'(uio_oe4), 16'h07);
    ui_in[1] = 1'b0;
    tick(2);

    // Basic window: code 3 -> 64 cycles, 5 pulses
    ui_in[7:3] = 5'd3;
    start_window();
    tick(3);
    pulses(5);
    wait_done(200, "basic_done_timeout");
    check_eq("basic_busy_cycles", 16'(busy_total - busy_snap), 16'd64);
    check_eq("basic_lo_byte", 16'(uo_out), 16'h05);
    check_eq("basic_ovf", 16'(uio_out[OVF_BIT]), 16'd0);
    ui_in[2] = 1'b1;
    #1;
    check_eq("basic_hi_byte", 16'(uo_out), 16'h00);
    ui_in[2] = 1'b0;
    #1;
    check_eq("basic_lo_byte4", 16'(uo_out4), 16'h05);
    tick(4);

    // Boundary: edge_pulse on the final COUNT cycle is counted
    ui_in[7:3] = 5'd0;
    start_window();
    tick(14);
    ui_in[0] = 1'b1;
    wait_done(40, "bnd_in_done_timeout");
    check_eq("bnd_in_result", 16'(uo_out), 16'h01);
    check_eq("bnd_in_busy_cycles", 16'(busy_total - busy_snap), 16'd16);
    ui_in[0] = 1'b0;
    tick(4);
    // One cycle later falls outside the window
    start_window();
    tick(15);
    ui_in[0] = 1'b1;
    wait_done(40, "bnd_out_done_timeout");
    check_eq("bnd_out_result", 16'(uo_out), 16'h00);
    ui_in[0] = 1'b0;
    tick(4);

    // Overflow on the 4-bit instance
    ui_in[7:3] = 5'd7;
    start_window();
    tick(3);
    pulses(20);
    wait_done(200, "ovf_done_timeout");
    check_eq("ovf_busy_cycles", 16'(busy_total - busy_snap), 16'd128);
    check_eq("ovf_result4", 16'(uo_out4), 16'h0F);
    check_eq("ovf_flag4", 16'(uio_out4[OVF_BIT]), 16'd1);
    check_eq("ovf_result16", 16'(uo_out), 16'h14);
    check_eq("ovf_flag16", 16'(uio_out[OVF_BIT]), 16'd0);
    tick(4);
    start_window();
    tick(3);
    pulses(3);
    wait_done(200, "ovf_rerun_timeout");
    check_eq("ovf_rerun_result4", 16'(uo_out4), 16'h03);
    check_eq("ovf_rerun_flag4", 16'(uio_out4[OVF_BIT]), 16'd0);
    tick(4);

    // Restart: start during COUNT ignored, start after DONE rearms
    ui_in[7:3] = 5'd1;
    start_window();
    tick(3);
    pulses(2);
    ui_in[1] = 1'b1;
    tick(2);
    ui_in[1] = 1'b0;
    check_eq("rs_busy_mid", 16'(uio_out[BUSY_BIT]), 16'd1);
    wait_done(80, "rs_first_timeout");
    check_eq("rs_first_busy_cycles", 16'(busy_total - busy_snap), 16'd32);
    check_eq("rs_first_result", 16'(uo_out), 16'h02);
    tick(2);
    start_window();
    tick(2);
    check_eq("rs_done_cleared", 16'(uio_out[DONE_BIT]), 16'd0);
    check_eq("rs_busy_second", 16'(uio_out[BUSY_BIT]), 16'd1);
    check_eq("rs_result_held", 16'(uo_out), 16'h02);
    pulses(1);
    check_eq("rs_result_held_late", 16'(uo_out), 16'h02);
    wait_done(80, "rs_second_timeout");
    check_eq("rs_second_result", 16'(uo_out), 16'h01);
    check_eq("rs_second_busy_cycles", 16'(busy_total - busy_snap), 16'd32);
    tick(2);

    // Reset mid-window
    ui_in[7:3] = 5'd2;
    start_window();
    tick(5);
    pulses(2);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_uio_out", 16'(uio_out), 16'h00);
    check_eq("mrst_uo_out", 16'(uo_out), 16'h00);
    check_eq("mrst_state", 16'(u_dut.r_state), 16'(IDLE));
    check_eq("mrst_uio_out4", 16'(uio_out4), 16'h00);
    tick(2);
    rst_n = 1'b1;
    busy_snap = busy_total;
    tick(10);
    check_eq("mrst_no_count", 16'(busy_total - busy_snap), 16'd0);
    check_eq("mrst_state_after", 16'(u_dut.r_state), 16'(IDLE));

    // ena stall: code 0 with 8 stalled cycles -> 24 busy cycles, stalled edge lost
    ui_in[7:3] = 5'd0;
    start_window();
    tick(4);
    ena = 1'b0;
    ui_in[0] = 1'b1;
    tick(8);
    ena = 1'b1;
    ui_in[0] = 1'b0;
    wait_done(60, "ena_done_timeout");
    check_eq("ena_busy_cycles", 16'(busy_total - busy_snap), 16'd24);
    check_eq("ena_lost_edge", 16'(uo_out), 16'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
